// File: rtl/montgomery_reduce_pipe.sv
// ---------------------------------------------------------------------------
// montgomery_reduce_pipe
//
// Three-stage pipelined Montgomery reducer: y = X * R^-1 mod Q, R = 2^K, for
// any odd modulus Q with R > Q. Each transaction selects lazy output
// ([0, 2Q)) or full output ([0, Q)). A tag rides along unchanged, and inputs
// at or above Q*R raise out_ovf (out_y is then meaningless).
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset; drops all in-flight work
//   in_valid   input transaction present
//   in_ready   block accepts this cycle
//   in_x       value to reduce, unsigned, XW bits
//   in_lazy    1: out_y in [0, 2Q); 0: out_y in [0, Q)
//   in_tag     opaque tag, TAGW bits
//   out_valid  result present
//   out_ready  downstream accepts
//   out_y      reduced result, QW bits (QW >= clog2(2Q) if lazy mode is used)
//   out_tag    tag of this result
//   out_ovf    input was >= Q*R
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer holding valid is never required to wait on ready
// combinationally; in_ready depends only on the stage valid bits, out_ready
// and rst, never on in_valid. While out_valid && !out_ready, out_y, out_tag
// and out_ovf stay stable.
// ---------------------------------------------------------------------------
module montgomery_reduce_pipe #(
    parameter int unsigned Q    = 3329,
    parameter int unsigned K    = 16,
    parameter int unsigned QINV = 3327,
    parameter int unsigned QW   = 12,
    parameter int unsigned XW   = 28,
    parameter int unsigned TAGW = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XW-1:0]   in_x,
    input  logic            in_lazy,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [QW-1:0]   out_y,
    output logic [TAGW-1:0] out_tag,
    output logic            out_ovf
);

    // t = x + m*Q needs one bit more than x; u = t >> K keeps the rest.
    localparam int unsigned TW = XW + 1;
    localparam int unsigned UW = TW - K;

    localparam logic [TW-1:0] Q_T    = TW'(Q);
    localparam logic [TW-1:0] QR_T   = Q_T << K;
    localparam logic [UW-1:0] Q_U    = UW'(Q);
    localparam logic [K-1:0]  QINV_K = K'(QINV);

    // ---------------- stage registers ----------------
    logic            s1_valid;
    logic [XW-1:0]   s1_x;
    logic [K-1:0]    s1_m;
    logic            s1_lazy;
    logic [TAGW-1:0] s1_tag;
    logic            s1_ovf;

    logic            s2_valid;
    logic [TW-1:0]   s2_t;
    logic            s2_lazy;
    logic [TAGW-1:0] s2_tag;
    logic            s2_ovf;

    logic            s3_valid;

    // ---------------- flow control ----------------
    // A stage may load when it is empty or its occupant leaves this cycle.
    logic s3_load;
    logic s2_load;
    logic s1_load;
    logic accept;

    assign s3_load   = !s3_valid || out_ready;
    assign s2_load   = !s2_valid || s3_load;
    assign s1_load   = !s1_valid || s2_load;
    assign in_ready  = s1_load && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = s3_valid;

    // ---------------- datapath ----------------
    logic [K-1:0]  m_next;
    logic          ovf_next;
    logic [TW-1:0] t_next;
    logic [UW-1:0] u;
    logic [UW-1:0] y_next;
    // The low K bits of t are zero by construction (m is chosen to cancel
    // them), so they are stored but never read.
    logic [K-1:0]  t_low_unused;

    always_comb begin
        m_next       = in_x[K-1:0] * QINV_K;
        ovf_next     = {1'b0, in_x} >= QR_T;
        t_next       = {1'b0, s1_x} + TW'(s1_m) * Q_T;
        u            = s2_t[TW-1:K];
        t_low_unused = s2_t[K-1:0];
        // For in-range x, u < 2Q, so one conditional subtract finishes it.
        y_next       = u;
        if (!s2_lazy && (u >= Q_U)) begin
            y_next = u - Q_U;
        end
    end

    // ---------------- sequential ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            out_y    <= '0;
            out_tag  <= '0;
            out_ovf  <= 1'b0;
        end else begin
            if (s1_load) s1_valid <= in_valid;
            if (s2_load) s2_valid <= s1_valid;
            if (s3_load) s3_valid <= s2_valid;

            if (accept) begin
                s1_x    <= in_x;
                s1_m    <= m_next;
                s1_lazy <= in_lazy;
                s1_tag  <= in_tag;
                s1_ovf  <= ovf_next;
            end

            if (s1_valid && s2_load) begin
                s2_t    <= t_next;
                s2_lazy <= s1_lazy;
                s2_tag  <= s1_tag;
                s2_ovf  <= s1_ovf;
            end

            // Output registers only change when a real result moves in, so
            // they hold stable under stall and stay zero after reset.
            if (s2_valid && s3_load) begin
                out_y   <= QW'(y_next);
                out_tag <= s2_tag;
                out_ovf <= s2_ovf;
            end
        end
    end

endmodule

// File: tb/tb_montgomery_reduce_pipe.sv
`timescale 1ns/1ps
// Bench for montgomery_reduce_pipe. QW is widened to 13 so lazy results up
// to 2Q-1 are representable. Full-mode expectations come from
// (x mod Q) * R^-1 mod Q with R^-1 found by search; lazy expectations use the
// defined u = (x + m*Q) / R and are cross-checked against full mode.
module tb_montgomery_reduce_pipe;
    localparam int unsigned Q    = 3329;
    localparam int unsigned K    = 16;
    localparam int unsigned QINV = 3327;
    localparam int unsigned QW   = 13;
    localparam int unsigned XW   = 28;
    localparam int unsigned TAGW = 10;
    localparam int unsigned R    = 1 << K;
    localparam int unsigned QR   = Q * R;
    localparam int unsigned EW   = 1 + TAGW + QW;

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XW-1:0]   in_x = '0;
    logic            in_lazy = 1'b0;
    logic [TAGW-1:0] in_tag = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [QW-1:0]   out_y;
    logic [TAGW-1:0] out_tag;
    logic            out_ovf;

    always #5 clk = ~clk;

    montgomery_reduce_pipe #(
        .Q(Q), .K(K), .QINV(QINV), .QW(QW), .XW(XW), .TAGW(TAGW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .in_lazy(in_lazy), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_tag(out_tag), .out_ovf(out_ovf)
    );

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int unsigned rinv = 0;
    logic [EW-1:0] exp_q[$];
    int            acc_q[$];
    logic [QW:0]   obs_q[$];   // {ovf, y} of each delivered result
    bit chk_lat = 1'b0;
    bit acc_flag = 1'b0;
    bit out_flag = 1'b0;
    bit s_in_ready = 1'b0;
    bit s_out_valid = 1'b0;
    bit stall_prev = 1'b0;
    logic [QW-1:0]   held_y;
    logic [TAGW-1:0] held_tag;
    logic            held_ovf;

    int unsigned kx[5] = '{0, 1, 65536, 327680, 218169343};
    int unsigned ky[5] = '{0, 169, 1, 5, 3160};

    function automatic logic [QW-1:0] model_y(input logic [XW-1:0] x, input logic lazy);
        longint unsigned xx;
        longint unsigned m;
        longint unsigned u;
        xx = longint'(x);
        if (!lazy) return QW'((xx % Q) * rinv % Q);
        m = ((xx % R) * QINV) % R;
        u = (xx + m * Q) / R;
        return QW'(u);
    endfunction

    // ---------------- driver / monitor ----------------
    // Samples handshakes at the falling edge, then advances past the next
    // rising edge. Inputs are set by the caller between calls.
    task automatic step();
        logic [EW-1:0] e;
        int a;
        logic ovf;
        @(negedge clk);
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        acc_flag    = !rst && in_valid && in_ready;
        out_flag    = !rst && out_valid && out_ready;
        if (!rst && stall_prev) begin
            checks++;
            if (out_valid !== 1'b1 || out_y !== held_y || out_tag !== held_tag || out_ovf !== held_ovf) begin
                errors++;
                $display("FAIL stall_hold: got v=%0b y=%0d tag=%0d ovf=%0b, required v=1 y=%0d tag=%0d ovf=%0b",
                         out_valid, out_y, out_tag, out_ovf, held_y, held_tag, held_ovf);
            end
        end
        stall_prev = !rst && out_valid && !out_ready;
        held_y = out_y; held_tag = out_tag; held_ovf = out_ovf;
        if (acc_flag) begin
            ovf = (in_x >= QR);
            exp_q.push_back({ovf, in_tag, model_y(in_x, in_lazy)});
            acc_q.push_back(cyc);
        end
        if (out_flag) begin
            obs_q.push_back({out_ovf, out_y});
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got tag=%0d y=%0d, required no output", out_tag, out_y);
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                if (out_tag !== e[QW +: TAGW] || out_ovf !== e[EW-1] || (!e[EW-1] && out_y !== e[QW-1:0])) begin
                    errors++;
                    $display("FAIL result: got tag=%0d ovf=%0b y=%0d, required tag=%0d ovf=%0b y=%0d",
                             out_tag, out_ovf, out_y, e[QW +: TAGW], e[EW-1], e[QW-1:0]);
                end
                if (chk_lat) begin
                    checks++;
                    if (cyc - a != 3) begin
                        errors++;
                        $display("FAIL latency: got %0d cycles, required 3 (tag=%0d)", cyc - a, out_tag);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [XW-1:0] x, input logic lazy, input logic [TAGW-1:0] tag);
        int n = 0;
        in_valid = 1'b1; in_x = x; in_lazy = lazy; in_tag = tag;
        step();
        while (!acc_flag && n < 50) begin
            step();
            n++;
        end
        in_valid = 1'b0;
        if (!acc_flag) begin
            checks++; errors++;
            $display("FAIL send_timeout: got no acceptance in 50 cycles, required acceptance (tag=%0d)", tag);
        end
    endtask

    task automatic drain(input int limit);
        int n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < limit) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d results pending, required 0", exp_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %0b, required 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || out_y !== '0 || out_tag !== '0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b y=%0d tag=%0d ovf=%0b, required all 0", out_valid, out_y, out_tag, out_ovf);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_y !== '0 || out_tag !== '0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_outputs: got v=%0b y=%0d tag=%0d ovf=%0b, required all 0", out_valid, out_y, out_tag, out_ovf);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset_in_ready: got %0b, required 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_params();
        longint unsigned p;
        p = longint'(Q) * QINV + 1;
        checks++;
        if (p % R != 0) begin
            errors++; $display("FAIL qinv: got (Q*QINV+1) mod R=%0d, required 0", p % R);
        end
    endtask

    task automatic test_known();
        chk_lat = 1'b1;
        obs_q.delete();
        for (int i = 0; i < 5; i++) begin
            send(XW'(kx[i]), 1'b0, TAGW'(i + 1));
            drain(10);
        end
        checks++;
        if (obs_q.size() != 5) begin
            errors++; $display("FAIL known_count: got %0d, required 5", obs_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (obs_q[i] !== {1'b0, QW'(ky[i])}) begin
                    errors++; $display("FAIL known_vec: x=%0d got %0d, required %0d", kx[i], obs_q[i], ky[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        chk_lat = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_x = XW'($urandom_range(0, QR - 1));
            in_lazy = 1'(i % 2);
            in_tag = TAGW'(200 + i);
            step();
            checks++;
            if (!acc_flag) begin
                errors++; $display("FAIL b2b_accept: got in_ready=%0b, required 1 (i=%0d)", s_in_ready, i);
            end
        end
        in_valid = 1'b0;
        drain(10);
    endtask

    task automatic test_ovf();
        chk_lat = 1'b1;
        obs_q.delete();
        send(XW'(QR), 1'b0, TAGW'(300));
        send(XW'(QR - 1), 1'b0, TAGW'(301));
        drain(10);
        checks++;
        if (obs_q.size() != 2) begin
            errors++; $display("FAIL ovf_count: got %0d, required 2", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0][QW] !== 1'b1) begin
                errors++; $display("FAIL ovf_at_qr: got %0b, required 1", obs_q[0][QW]);
            end
            checks++;
            if (obs_q[1] !== {1'b0, QW'(3160)}) begin
                errors++; $display("FAIL ovf_below_qr: got ovf=%0b y=%0d, required ovf=0 y=3160", obs_q[1][QW], obs_q[1][QW-1:0]);
            end
        end
    endtask

    task automatic test_lazy();
        logic [XW-1:0] xs;
        int unsigned lz, fl;
        bit found = 1'b0;
        chk_lat = 1'b1;
        xs = '0;
        for (int i = 0; i < 4096 && !found; i++) begin
            xs = XW'(QR - 1 - i);
            if (model_y(xs, 1'b1) >= QW'(Q)) found = 1'b1;
        end
        obs_q.delete();
        send(xs, 1'b1, TAGW'(400));
        send(xs, 1'b0, TAGW'(401));
        for (int i = 0; i < 48; i++) begin
            xs = XW'($urandom_range(0, QR - 1));
            send(xs, 1'b1, TAGW'(402 + 2 * i));
            send(xs, 1'b0, TAGW'(403 + 2 * i));
        end
        drain(20);
        checks++;
        if (obs_q.size() != 98) begin
            errors++; $display("FAIL lazy_count: got %0d, required 98", obs_q.size());
        end else begin
            lz = int'(obs_q[0][QW-1:0]);
            fl = int'(obs_q[1][QW-1:0]);
            checks++;
            if (lz < Q || lz >= 2 * Q || fl != lz - Q) begin
                errors++; $display("FAIL lazy_high: got lazy=%0d full=%0d, required lazy in [Q,2Q) and full=lazy-Q", lz, fl);
            end
            for (int i = 1; i < 49; i++) begin
                lz = int'(obs_q[2 * i][QW-1:0]);
                fl = int'(obs_q[2 * i + 1][QW-1:0]);
                checks++;
                if (lz >= 2 * Q || lz % Q != fl) begin
                    errors++; $display("FAIL lazy_vs_full: got lazy=%0d full=%0d, required lazy<2Q and lazy mod Q = full", lz, fl);
                end
            end
        end
    endtask

    task automatic test_full_drain();
        int sent = 0;
        chk_lat = 1'b0;
        obs_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_x = XW'($urandom_range(0, QR - 1));
            in_lazy = 1'b0;
            in_tag = TAGW'(500 + sent);
            step();
            if (acc_flag) sent++;
        end
        checks++;
        if (sent != 3 || s_in_ready !== 1'b0 || s_out_valid !== 1'b1) begin
            errors++; $display("FAIL fill: got accepted=%0d in_ready=%0b out_valid=%0b, required 3/0/1", sent, s_in_ready, s_out_valid);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = (sent < 5);
            in_x = XW'($urandom_range(0, QR - 1));
            in_tag = TAGW'(500 + sent);
            step();
            checks++;
            if (!out_flag || (i < 2 && !acc_flag)) begin
                errors++; $display("FAIL drain_accept: cycle %0d got out=%0b acc=%0b, required out=1 acc=%0b", i, out_flag, acc_flag, (i < 2));
            end
            if (acc_flag) sent++;
        end
        drain(10);
        checks++;
        if (obs_q.size() != 5) begin
            errors++; $display("FAIL full_drain_count: got %0d, required 5", obs_q.size());
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        int guard = 0;
        chk_lat = 1'b0;
        obs_q.delete();
        while (n < 512 && guard < 20000) begin
            in_valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) in_x = XW'($urandom_range(QR, (1 << XW) - 1));
            else in_x = XW'($urandom_range(0, QR - 1));
            in_lazy = 1'($urandom_range(0, 1));
            in_tag = TAGW'(n);
            out_ready = 1'($urandom_range(0, 1));
            step();
            if (acc_flag) n++;
            guard++;
        end
        checks++;
        if (n != 512) begin
            errors++; $display("FAIL bp_timeout: got %0d accepted, required 512", n);
        end
        drain(50);
        checks++;
        if (obs_q.size() != 512) begin
            errors++; $display("FAIL bp_count: got %0d outputs, required 512", obs_q.size());
        end
    endtask

    task automatic test_reset_mid();
        chk_lat = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_x = XW'($urandom_range(0, QR - 1));
            in_lazy = 1'b0;
            in_tag = TAGW'(600 + i);
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        exp_q.delete();
        acc_q.delete();
        rst = 1'b0;
        obs_q.delete();
        step();
        checks++;
        if (s_out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_valid: got %0b, required 0", s_out_valid);
        end
        repeat (6) step();
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL reset_mid_stale: got %0d outputs, required 0", obs_q.size());
        end
        send(XW'(65536), 1'b0, TAGW'(700));
        drain(10);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== {1'b0, QW'(1)}) begin
            errors++; $display("FAIL reset_mid_after: got n=%0d first=%0d, required n=1 y=1", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 0);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int r = 1; r < int'(Q); r++) begin
            if ((longint'(R) * r) % Q == 1) rinv = r;
        end
        test_reset();
        test_params();
        test_known();
        test_back_to_back();
        test_ovf();
        test_lazy();
        test_full_drain();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion by 1 ms, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
